// File: rtl/ca_line_renderer.sv
// Elementary cellular-automaton pixel source: seed row on line 0, each later
// visible line is the next generation of the previous one under an 8-bit rule.
module ca_line_renderer #(
    parameter int unsigned WIDTH        = 1280,
    parameter int unsigned V_VISIBLE    = 1024,
    parameter int unsigned DELAY        = 16,
    parameter int unsigned SEED_POS     = 640,
    parameter logic [7:0]  RULE_DEFAULT = 8'd30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] prefetch_x,
    input  logic [10:0] counter_y,
    input  logic        in_display,
    input  logic [7:0]  rule_in,
    input  logic        rule_load,
    output logic        pixel_out,
    output logic        seeding
);

    localparam int unsigned XW = 11;
    localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    // pixel_q is the last stage, so DELAY-1 shift stages precede it
    localparam int unsigned DL = DELAY - 1;

    typedef enum logic [1:0] {ST_SEED, ST_WAIT, ST_RENDER} state_t;

    state_t           state_q;
    logic [IW-1:0]    cnt_q;
    logic             cur_sel_q;
    logic             active_dly_q;
    logic [7:0]       rule_pend_q;
    logic [7:0]       rule_act_q;
    logic [DL-1:0]    dl_q;
    logic [WIDTH-1:0] buf_q [2];
    logic             pixel_q;
    logic             seeding_q;

    logic             active_d;
    logic             start_d;
    logic             render_d;
    logic [WIDTH-1:0] cur_row_d;
    logic [IW-1:0]    xi_d;
    logic [IW-1:0]    li_d;
    logic [IW-1:0]    ri_d;
    logic [2:0]       hood_d;
    logic             next_bit_d;
    logic             push_d;

    // Neighbourhood lookup with wrap-around done on the index, not by overflow
    always_comb begin
        active_d   = (prefetch_x < XW'(WIDTH)) && (counter_y < XW'(V_VISIBLE));
        start_d    = (state_q == ST_WAIT) && (counter_y == '0) && (prefetch_x == '0);
        render_d   = active_d && ((state_q == ST_RENDER) || start_d);
        cur_row_d  = buf_q[cur_sel_q];
        xi_d       = IW'(prefetch_x);
        li_d       = (prefetch_x == '0) ? IW'(WIDTH - 1) : IW'(prefetch_x - 11'd1);
        ri_d       = (prefetch_x == XW'(WIDTH - 1)) ? '0 : IW'(prefetch_x + 11'd1);
        hood_d     = {cur_row_d[li_d], cur_row_d[xi_d], cur_row_d[ri_d]};
        next_bit_d = rule_act_q[hood_d];
        push_d     = render_d ? cur_row_d[xi_d] : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_SEED;
            cnt_q        <= '0;
            cur_sel_q    <= 1'b0;
            active_dly_q <= 1'b0;
            rule_pend_q  <= RULE_DEFAULT;
            rule_act_q   <= RULE_DEFAULT;
            dl_q         <= '0;
            pixel_q      <= 1'b0;
            seeding_q    <= 1'b1;
        end else begin
            active_dly_q <= active_d;
            dl_q         <= (dl_q << 1) | DL'(push_d);
            pixel_q      <= dl_q[DL-1] & in_display;

            if (rule_load) begin
                rule_pend_q <= rule_in;
            end
            if (render_d) begin
                buf_q[!cur_sel_q][xi_d] <= next_bit_d;
            end

            case (state_q)
                ST_SEED: begin
                    buf_q[cur_sel_q][cnt_q] <= (cnt_q == IW'(SEED_POS));
                    cnt_q <= cnt_q + 1'b1;
                    // Pending value from before this edge: a same-cycle load waits a frame
                    if (cnt_q == IW'(WIDTH - 1)) begin
                        rule_act_q <= rule_pend_q;
                        seeding_q  <= 1'b0;
                        state_q    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (start_d) begin
                        state_q <= ST_RENDER;
                    end
                end
                ST_RENDER: begin
                    if (active_dly_q && !active_d) begin
                        cur_sel_q <= !cur_sel_q;
                    end
                    if ((counter_y >= XW'(V_VISIBLE)) && !active_d) begin
                        state_q   <= ST_SEED;
                        cnt_q     <= '0;
                        seeding_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_SEED;
                end
            endcase
        end
    end

    assign pixel_out = pixel_q;
    assign seeding   = seeding_q;

endmodule

// File: tb/tb_ca_line_renderer.sv
// Scoreboard bench: a 1280-wide and an 8-wide renderer share a shortened sync
// timing; expected rows are queued at line start and checked as pixels arrive.
module tb_ca_line_renderer;

    localparam int unsigned BW      = 1280;
    localparam int unsigned SW      = 8;
    localparam int unsigned VV      = 6;
    localparam int unsigned DLY     = 16;
    localparam int unsigned H_TOTAL = 1320;
    localparam int unsigned V_TOTAL = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] px;
    logic [10:0] cy;
    logic        disp_b;
    logic        disp_s;
    logic [7:0]  rule_in;
    logic        rule_load;
    logic        pix_b;
    logic        seed_b;
    logic        pix_s;
    logic        seed_s;

    always #5 clk = ~clk;

    ca_line_renderer #(
        .WIDTH(BW), .V_VISIBLE(VV), .DELAY(DLY), .SEED_POS(640), .RULE_DEFAULT(8'd30)
    ) u_big (
        .clk(clk), .rst(rst), .prefetch_x(px), .counter_y(cy), .in_display(disp_b),
        .rule_in(rule_in), .rule_load(rule_load), .pixel_out(pix_b), .seeding(seed_b)
    );

    ca_line_renderer #(
        .WIDTH(SW), .V_VISIBLE(VV), .DELAY(DLY), .SEED_POS(4), .RULE_DEFAULT(8'h5A)
    ) u_small (
        .clk(clk), .rst(rst), .prefetch_x(px), .counter_y(cy), .in_display(disp_s),
        .rule_in(rule_in), .rule_load(rule_load), .pixel_out(pix_s), .seeding(seed_s)
    );

    typedef struct {
        logic [BW-1:0] row;
        logic [BW-1:0] mask;
        int            frame;
        int            line;
    } exp_t;

    exp_t q_b[$];
    exp_t q_s[$];

    int errors = 0;
    int checks = 0;
    int x;
    int y;
    int frame;

    // Hand-computed 8-wide rows: rule 90, 0xFF, 0xFF, 0x96 (reset at line 3), rule 90
    logic [7:0] small_tab [0:4][0:5] = '{
        '{8'h10, 8'h28, 8'h44, 8'hAA, 8'h00, 8'h00},
        '{8'h10, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF},
        '{8'h10, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF},
        '{8'h10, 8'h38, 8'h54, 8'hD6, 8'h00, 8'h00},
        '{8'h10, 8'h28, 8'h44, 8'hAA, 8'h00, 8'h00}
    };

    function automatic logic [BW-1:0] next_gen(input logic [BW-1:0] row, input logic [7:0] rule);
        logic [BW-1:0] ng;
        logic [2:0]    h;
        ng = '0;
        for (int i = 0; i < int'(BW); i++) begin
            h     = {row[(i + int'(BW) - 1) % int'(BW)], row[i], row[(i + 1) % int'(BW)]};
            ng[i] = rule[h];
        end
        return ng;
    endfunction

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d (frame=%0d y=%0d x=%0d)", name, got, want, frame, y, x);
        end
    endtask

    task automatic check_row(input string name, input exp_t e, input logic [BW-1:0] got, input int w);
        logic [BW-1:0] g;
        logic [BW-1:0] r;
        int            bad;
        g = got & e.mask;
        r = e.row & e.mask;
        checks++;
        if (g !== r) begin
            errors++;
            bad = -1;
            for (int i = w - 1; i >= 0; i--) begin
                if (g[i] !== r[i]) bad = i;
            end
            $display("FAIL %s frame=%0d line=%0d first_bad_x=%0d got_bit=%b want_bit=%b got_ones=%0d want_ones=%0d",
                     name, e.frame, e.line, bad, g[bad], r[bad], $countones(g), $countones(r));
        end
    endtask

    // Monitor: assemble each displayed line and compare against the queued row
    logic [BW-1:0] cap_b = '0;
    logic [BW-1:0] cap_s = '0;
    always @(negedge clk) begin
        exp_t e;
        if (y < int'(VV)) begin
            if (x >= int'(DLY) && x < int'(BW + DLY)) cap_b[x - int'(DLY)] = pix_b;
            if (x >= int'(DLY) && x < int'(SW + DLY)) cap_s[x - int'(DLY)] = pix_s;
            if (x == int'(BW + DLY)) begin
                if (q_b.size() == 0) begin
                    chk("big_queue_empty", 0, 1);
                end else begin
                    e = q_b.pop_front();
                    check_row("big_row", e, cap_b, int'(BW));
                end
                cap_b = '0;
            end
            if (x == int'(SW + DLY)) begin
                if (q_s.size() == 0) begin
                    chk("small_queue_empty", 0, 1);
                end else begin
                    e = q_s.pop_front();
                    check_row("small_row", e, cap_s, int'(SW));
                end
                cap_s = '0;
            end
        end
    end

    // Stimulus: sync timing, rule loads, mid-frame reset, expected-row pushes
    initial begin
        logic [BW-1:0] row_b;
        logic [7:0]    m_pend;
        logic [7:0]    m_next;
        logic [7:0]    m_act;
        exp_t          e;
        int            cyc;
        int            since_rst;
        bit            track;
        bit            mid_rst;

        x = 0; y = int'(VV); frame = -1;
        rst = 1'b1; rule_load = 1'b0; rule_in = 8'h00; disp_b = 1'b0; disp_s = 1'b0;
        px = 11'(x); cy = 11'(y);
        m_pend = 8'd30; m_next = 8'd30; m_act = 8'd30;
        row_b = '0;
        cyc = 0; since_rst = 0; track = 1'b0;

        while (!(frame == 4 && y == int'(VV) && x == 50)) begin
            @(posedge clk);
            #1;
            cyc++;

            if (cyc == 2) begin
                chk("reset_pixel_big", int'(pix_b), 0);
                chk("reset_seeding_big", int'(seed_b), 1);
                chk("reset_pixel_small", int'(pix_s), 0);
                chk("reset_seeding_small", int'(seed_s), 1);
            end
            if (track) begin
                since_rst++;
                if (since_rst == 1) begin
                    chk("midrst_pixel_big", int'(pix_b), 0);
                    chk("midrst_seeding_big", int'(seed_b), 1);
                    chk("midrst_pixel_small", int'(pix_s), 0);
                    chk("midrst_seeding_small", int'(seed_s), 1);
                end
                if (since_rst == int'(SW))     chk("small_seed_last", int'(seed_s), 1);
                if (since_rst == int'(SW) + 1) chk("small_seed_fall", int'(seed_s), 0);
                if (since_rst == int'(BW))     chk("big_seed_last", int'(seed_b), 1);
                if (since_rst == int'(BW) + 1) begin
                    chk("big_seed_fall", int'(seed_b), 0);
                    track = 1'b0;
                end
            end

            x++;
            if (x == int'(H_TOTAL)) begin
                x = 0;
                y++;
                if (y == int'(V_TOTAL)) y = 0;
            end
            if (x == 0 && y == 0) frame++;

            mid_rst = (frame == 3 && y == 3 && x == 500);
            rst = (cyc < 3) || mid_rst;
            if (mid_rst) begin
                m_pend = 8'd30; m_next = 8'd30;
                since_rst = 0; track = 1'b1;
            end

            disp_b = (y < int'(VV)) && !(frame == 0 && y == 3);
            disp_s = (y < int'(VV));

            // Last seed cycle of the wide instance: snapshot before this cycle's load
            if (y == int'(VV) && x == int'(BW)) m_next = m_pend;

            rule_load = 1'b0;
            if (frame == 0 && y == 5 && x == 100) begin
                rule_load = 1'b1; rule_in = 8'hFF;
            end
            if (frame == 1 && y == int'(VV) && x == int'(BW)) begin
                rule_load = 1'b1; rule_in = 8'h96;
            end
            if (rule_load) m_pend = rule_in;

            if (x == 0 && y < int'(VV) && frame >= 0 && frame <= 4) begin
                if (y == 0) begin
                    m_act = m_next;
                    row_b = '0;
                    row_b[640] = 1'b1;
                end
                e.frame = frame; e.line = y;
                e.mask  = '1;
                e.row   = row_b;
                if (frame == 0 && y == 0) begin
                    e.row = '0; e.row[640] = 1'b1;
                end
                if (frame == 0 && y == 1) begin
                    e.row = '0; e.row[639] = 1'b1; e.row[640] = 1'b1; e.row[641] = 1'b1;
                end
                if (frame == 0 && y == 2) begin
                    e.row = '0; e.row[638] = 1'b1; e.row[639] = 1'b1; e.row[642] = 1'b1;
                end
                if (frame == 0 && y == 3) e.row = '0;
                if (frame == 3 && y == 3) begin
                    e.mask = '0;
                    for (int i = 0; i <= 484; i++) e.mask[i] = 1'b1;
                end
                if (frame == 3 && y > 3) e.row = '0;
                q_b.push_back(e);
                row_b = next_gen(row_b, m_act);

                e.mask = '1;
                e.row  = '0;
                e.row[7:0] = small_tab[frame][y];
                q_s.push_back(e);
            end

            px = 11'(x);
            cy = 11'(y);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
